// File: rtl/ahb_pkg.sv
// Shared AHB-Lite transfer encodings, response codes and byte-lane helper.
// No logic latency; definitions only.
// No flow control; definitions only.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3,
        HSIZE_4W    = 3'd4,
        HSIZE_8W    = 3'd5,
        HSIZE_16W   = 3'd6,
        HSIZE_32W   = 3'd7
    } hsize_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Little-endian byte lanes touched by a transfer of the given size.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size)
            HSIZE_BYTE: lane_mask = 4'b0001 << addr_lo;
            HSIZE_HALF: lane_mask = 4'b0011 << addr_lo;
            default:    lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_mem_array.sv
// Word-wide storage with per-byte write enables and a registered read port.
// Read data appears one cycle after rd_en; writes land on the same edge.
// No backpressure; always accepts one read and one write per cycle.
module ahb_mem_array #(
    parameter int WORDS      = 256,
    parameter int IDX_W      = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [3:0]            wr_be,
    input  logic [DATA_WIDTH-1:0] wr_dat,
    input  logic                  rd_en,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_dat
);

    logic [DATA_WIDTH-1:0] mem [WORDS];

    // A same-edge read of a word being written returns the old contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_dat[8*i +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_dat <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave with configurable wait states and two-cycle ERROR.
// Zero-wait by default; WAIT_STATES extra data-phase cycles per OKAY transfer.
// Stalls the bus by dropping s_hready during wait and ERR1 cycles.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_WORDS   = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'h0000_0000),
    parameter int                    WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  s_hsel,
    input  logic [ADDR_WIDTH-1:0] s_haddr,
    input  logic [1:0]            s_htrans,
    input  logic                  s_hwrite,
    input  logic [2:0]            s_hsize,
    input  logic [2:0]            s_hburst,
    input  logic                  s_hmastlock,
    input  logic [DATA_WIDTH-1:0] s_hwdata,
    input  logic                  s_hready_in,
    output logic                  s_hready,
    output logic                  s_hresp,
    output logic [DATA_WIDTH-1:0] s_hrdata
);

    localparam int                IDX_W     = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(4 * MEM_WORDS);
    localparam logic [2:0]        WS        = 3'(WAIT_STATES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR1 = 2'd2;
    localparam logic [1:0] ST_ERR2 = 2'd3;

    typedef struct packed {
        logic             vld;
        logic             err;
        logic             write;
        logic [IDX_W-1:0] idx;
        logic [3:0]       be;
        logic             fwd;
    } dphase_t;

    logic [1:0]            state, state_nxt;
    logic [2:0]            wait_cnt, wait_cnt_nxt;
    dphase_t               dp;
    logic [DATA_WIDTH-1:0] fwd_dat;
    logic [3:0]            fwd_be;
    logic [DATA_WIDTH-1:0] mem_rdat;
    logic [DATA_WIDTH-1:0] rd_merged;

    logic [ADDR_WIDTH-1:0] offset;
    logic                  borrow;
    logic                  in_range, bad_size, misaligned, active;
    logic                  accept, req_err, req_ok;
    logic [IDX_W-1:0]      req_idx;
    logic [3:0]            req_be;
    logic                  wr_en, rd_en, fwd_hit;
    logic                  unused_ok;

    // Address-phase decode.
    assign {borrow, offset} = {1'b0, s_haddr} - {1'b0, BASE_ADDR};
    assign in_range   = !borrow && ({1'b0, offset} < MEM_BYTES);
    assign bad_size   = s_hsize > HSIZE_WORD;
    assign misaligned = ((s_hsize == HSIZE_HALF) && s_haddr[0]) ||
                        ((s_hsize == HSIZE_WORD) && (s_haddr[1:0] != 2'b00));
    assign active     = (s_htrans == HTRANS_NONSEQ) || (s_htrans == HTRANS_SEQ);
    assign accept     = s_hsel && s_hready_in && active;
    assign req_err    = accept && (!in_range || bad_size || misaligned);
    assign req_ok     = accept && !req_err;
    assign req_idx    = offset[IDX_W+1:2];
    assign req_be     = lane_mask(s_hsize, s_haddr[1:0]);

    assign unused_ok = ^{s_hburst, s_hmastlock, offset[1:0], offset[ADDR_WIDTH-1:IDX_W+2]};

    always_comb begin
        s_hready = 1'b1;
        s_hresp  = HRESP_OKAY;
        case (state)
            ST_WAIT: s_hready = (wait_cnt == 3'd0);
            ST_ERR1: begin
                s_hready = 1'b0;
                s_hresp  = HRESP_ERROR;
            end
            ST_ERR2: s_hresp = HRESP_ERROR;
            default: ;
        endcase
    end

    // A reset cycle abandons the pending write instead of committing it.
    assign wr_en   = dp.vld && dp.write && !dp.err && s_hready && !hreset;
    assign rd_en   = req_ok && !s_hwrite && !hreset;
    assign fwd_hit = wr_en && (dp.idx == req_idx);

    // New transfers are only taken in cycles where this slave reports ready.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        if (state == ST_ERR1) begin
            state_nxt = ST_ERR2;
        end else if (!s_hready) begin
            wait_cnt_nxt = wait_cnt - 3'd1;
        end else if (req_err) begin
            state_nxt    = ST_ERR1;
            wait_cnt_nxt = 3'd0;
        end else if (req_ok && (WS != 3'd0)) begin
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = WS;
        end else begin
            state_nxt    = ST_IDLE;
            wait_cnt_nxt = 3'd0;
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state    <= ST_IDLE;
            wait_cnt <= 3'd0;
            dp       <= '0;
            fwd_dat  <= '0;
            fwd_be   <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (s_hready_in) begin
                dp.vld   <= accept;
                dp.err   <= req_err;
                dp.write <= s_hwrite;
                dp.idx   <= req_idx;
                dp.be    <= req_be;
                dp.fwd   <= fwd_hit && req_ok && !s_hwrite;
                fwd_dat  <= s_hwdata;
                fwd_be   <= dp.be;
            end
        end
    end

    // Bytes written on the same edge the read was launched bypass the array.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rd_merged[8*i +: 8] = (dp.fwd && fwd_be[i]) ? fwd_dat[8*i +: 8] : mem_rdat[8*i +: 8];
        end
        s_hrdata = (dp.vld && !dp.write && !dp.err && s_hready) ? rd_merged : '0;
    end

    ahb_mem_array #(
        .WORDS      (MEM_WORDS),
        .IDX_W      (IDX_W),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk    (hclk),
        .wr_en  (wr_en),
        .wr_idx (dp.idx),
        .wr_be  (dp.be),
        .wr_dat (s_hwdata),
        .rd_en  (rd_en),
        .rd_idx (req_idx),
        .rd_dat (mem_rdat)
    );

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: pipelined AHB master driving a zero-wait and a
// three-wait instance, checked against a byte-level memory model.
module tb_ahb_slave_mem;

    logic        clk = 1'b0;
    logic        hreset;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hmastlock;
    logic [31:0] hwdata;
    int          tgt;

    logic        ready0, ready3, resp0, resp3;
    logic [31:0] rdata0, rdata3;
    logic        ready_o, resp_o;
    logic [31:0] rdata_o;

    always #5 clk = ~clk;

    assign ready_o = (tgt == 0) ? ready0 : ready3;
    assign resp_o  = (tgt == 0) ? resp0  : resp3;
    assign rdata_o = (tgt == 0) ? rdata0 : rdata3;

    ahb_slave_mem #(.WAIT_STATES(0)) u_ws0 (
        .hclk(clk), .hreset(hreset), .s_hsel(hsel && (tgt == 0)), .s_haddr(haddr),
        .s_htrans(htrans), .s_hwrite(hwrite), .s_hsize(hsize), .s_hburst(hburst),
        .s_hmastlock(hmastlock), .s_hwdata(hwdata), .s_hready_in(ready_o),
        .s_hready(ready0), .s_hresp(resp0), .s_hrdata(rdata0)
    );

    ahb_slave_mem #(.WAIT_STATES(3)) u_ws3 (
        .hclk(clk), .hreset(hreset), .s_hsel(hsel && (tgt == 3)), .s_haddr(haddr),
        .s_htrans(htrans), .s_hwrite(hwrite), .s_hsize(hsize), .s_hburst(hburst),
        .s_hmastlock(hmastlock), .s_hwdata(hwdata), .s_hready_in(ready_o),
        .s_hready(ready3), .s_hresp(resp3), .s_hrdata(rdata3)
    );

    typedef struct {
        logic [1:0]  trans;
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [31:0] wdata;
    } xfer_t;

    xfer_t       xq[$];
    logic [31:0] mdl [2][16];
    int          vectors;
    int          miscompares;
    logic [31:0] last_rd;
    int          last_waits;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic int slot();
        return (tgt == 0) ? 0 : 1;
    endfunction

    function automatic bit is_err(input xfer_t x);
        int unsigned nb;
        nb = 1 << x.size;
        return (x.size > 3'd2) || ((x.addr % nb) != 0) || (x.addr >= 32'h400);
    endfunction

    function automatic void model_write(input xfer_t x);
        int lo, nb, w;
        lo = int'(x.addr % 4);
        nb = 1 << x.size;
        w  = int'((x.addr / 4) % 16);
        for (int b = 0; b < 4; b++) begin
            if (b >= lo && b < lo + nb) mdl[slot()][w][8*b +: 8] = x.wdata[8*b +: 8];
        end
    endfunction

    task automatic push(input logic [1:0] tr, input logic wr, input logic [31:0] a,
                        input logic [2:0] sz, input logic [2:0] bu, input logic [31:0] wd);
        xfer_t x;
        x.trans = tr; x.write = wr; x.addr = a; x.size = sz; x.burst = bu; x.wdata = wd;
        xq.push_back(x);
    endtask

    task automatic drive_addr(input bit v, input xfer_t x);
        hsel      = v;
        htrans    = v ? x.trans : 2'b00;
        haddr     = v ? x.addr : 32'h0;
        hwrite    = v && x.write;
        hsize     = v ? x.size : 3'd0;
        hburst    = v ? x.burst : 3'd0;
        hmastlock = 1'($urandom_range(0, 1));
    endtask

    // One data phase: per-cycle ready/resp expectations, data on the ready cycle.
    task automatic data_phase(input bit v, input xfer_t c);
        bit          act, err, done, exp_rdy;
        int          k, ws;
        logic [31:0] erd;
        act = v && c.trans[1];
        err = act && is_err(c);
        ws  = (tgt == 0) ? 0 : 3;
        erd = (act && !err && !c.write) ? mdl[slot()][(c.addr / 4) % 16] : 32'h0;
        k = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            exp_rdy = !act ? 1'b1 : (err ? (k >= 1) : (k >= ws));
            chk("hready", 32'(ready_o), 32'(exp_rdy));
            chk("hresp", 32'(resp_o), 32'(err));
            if (ready_o === 1'b1) begin
                chk("hrdata", rdata_o, erd);
                if (act && !c.write) begin
                    last_rd    = rdata_o;
                    last_waits = k;
                end
                done = 1;
            end else if (k >= 10) begin
                chk("ready_timeout", 32'(ready_o), 32'd1);
                done = 1;
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic run();
        xfer_t cur;
        bit    cur_v;
        int    n;
        n = xq.size();
        cur_v = 0;
        cur = '{default: 0};
        for (int i = 0; i <= n; i++) begin
            if (i < n) drive_addr(1, xq[i]);
            else drive_addr(0, cur);
            hwdata = (cur_v && cur.write) ? cur.wdata : $urandom;
            data_phase(cur_v, cur);
            if (cur_v && cur.trans[1] && cur.write && !is_err(cur)) model_write(cur);
            if (i < n) cur = xq[i];
            cur_v = (i < n);
        end
        xq.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        xfer_t       x;
        logic [31:0] old_val;
        vectors = 0;
        miscompares = 0;
        last_rd = '0;
        last_waits = 0;
        tgt = 0;
        hreset = 1'b1;
        x = '{default: 0};
        drive_addr(0, x);
        hwdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 hreset = 1'b0;

        @(negedge clk);
        chk("rst_ready0", 32'(ready0), 32'd1);
        chk("rst_resp0", 32'(resp0), 32'd0);
        chk("rst_rdata0", rdata0, 32'h0);
        chk("rst_ready3", 32'(ready3), 32'd1);
        chk("rst_resp3", 32'(resp3), 32'd0);
        chk("rst_rdata3", rdata3, 32'h0);
        @(posedge clk); #1;

        // Preload the words used below in both instances.
        for (int s = 0; s < 2; s++) begin
            tgt = (s == 0) ? 0 : 3;
            for (int w = 0; w < 16; w++) push(2'b10, 1'b1, 32'(w * 4), 3'd2, 3'd0, $urandom);
            run();
        end

        // Write then read the same word back-to-back with no wait states.
        tgt = 0;
        push(2'b10, 1'b1, 32'h10, 3'd2, 3'd0, 32'hDEADBEEF);
        push(2'b10, 1'b0, 32'h10, 3'd2, 3'd0, 32'h0);
        run();
        chk("fwd_read", last_rd, 32'hDEADBEEF);
        chk("fwd_waits", 32'(last_waits), 32'd0);

        // Three wait states on a read.
        tgt = 3;
        push(2'b10, 1'b0, 32'h04, 3'd2, 3'd0, 32'h0);
        run();
        chk("ws3_waits", 32'(last_waits), 32'd3);

        // Out-of-range write errors and must not alias onto word 0.
        tgt = 0;
        push(2'b10, 1'b1, 32'h400, 3'd2, 3'd0, $urandom);
        push(2'b10, 1'b0, 32'h00, 3'd2, 3'd0, 32'h0);
        run();

        // Byte merge, then a misaligned halfword that must error.
        push(2'b10, 1'b1, 32'h20, 3'd2, 3'd0, 32'h11223344);
        push(2'b10, 1'b1, 32'h21, 3'd0, 3'd0, 32'h0000A500);
        push(2'b10, 1'b0, 32'h20, 3'd2, 3'd0, 32'h0);
        run();
        chk("byte_merge", last_rd, 32'h1122A544);
        push(2'b10, 1'b1, 32'h21, 3'd1, 3'd0, 32'hFFFFFFFF);
        push(2'b10, 1'b0, 32'h20, 3'd2, 3'd0, 32'h0);
        run();
        chk("half_err_nowrite", last_rd, 32'h1122A544);

        // INCR4 with a BUSY beat, on the wait-state instance.
        tgt = 3;
        push(2'b10, 1'b1, 32'h30, 3'd2, 3'd3, $urandom);
        push(2'b11, 1'b1, 32'h34, 3'd2, 3'd3, $urandom);
        push(2'b01, 1'b1, 32'h38, 3'd2, 3'd3, $urandom);
        push(2'b11, 1'b1, 32'h38, 3'd2, 3'd3, $urandom);
        push(2'b11, 1'b1, 32'h3C, 3'd2, 3'd3, $urandom);
        for (int w = 0; w < 4; w++) push(2'b10, 1'b0, 32'(32'h30 + w * 4), 3'd2, 3'd0, 32'h0);
        run();

        // Reset during the wait cycles of a write abandons it.
        old_val = mdl[1][2];
        x = '{trans: 2'b10, write: 1'b1, addr: 32'h08, size: 3'd2, burst: 3'd0, wdata: ~old_val};
        drive_addr(1, x);
        @(posedge clk); #1;
        drive_addr(0, x);
        hwdata = ~old_val;
        @(negedge clk);
        chk("rst_mid_wait", 32'(ready3), 32'd0);
        @(posedge clk); #1;
        hreset = 1'b1;
        @(posedge clk); #1;
        hreset = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", 32'(ready3), 32'd1);
        chk("rst_mid_resp", 32'(resp3), 32'd0);
        chk("rst_mid_rdata", rdata3, 32'h0);
        @(posedge clk); #1;
        push(2'b10, 1'b0, 32'h08, 3'd2, 3'd0, 32'h0);
        run();
        chk("rst_old_value", last_rd, old_val);

        // Random mixed traffic on both instances.
        for (int s = 0; s < 2; s++) begin
            tgt = (s == 0) ? 0 : 3;
            for (int j = 0; j < 80; j++) begin
                logic [31:0] a;
                logic [2:0]  sz;
                a  = ($urandom_range(0, 7) == 0) ? 32'(32'h400 + $urandom_range(0, 63))
                                                 : 32'($urandom_range(0, 63));
                sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
                push(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, sz,
                     3'($urandom_range(0, 7)), $urandom);
            end
            run();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
